// File: rtl/mips_load_pkg.sv
// Opcode constants, FSM states and request legality checks for the MIPS load unit.
// LOAD_SIGNED_EN adds LB/LH to the set of supported opcodes.
package mips_load_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic v;
    case (op)
      OP_LW, OP_LBU, OP_LHU: v = 1'b1;
`ifdef LOAD_SIGNED_EN
      OP_LB, OP_LH:          v = 1'b1;
`endif
      default:               v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic addr_misaligned(input logic [5:0] op, input logic [1:0] lo);
    logic v;
    case (op)
      OP_LH, OP_LHU: v = lo[0];
      OP_LW:         v = (lo != 2'b00);
      default:       v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational little-endian lane select and zero/sign extension of a read word.
// Zero latency, no flow control; LOAD_SIGNED_EN enables the LB/LH sign-extending paths.
module load_align_ext
  import mips_load_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      OP_LBU: o_data = {24'h0, w_byte};
      OP_LHU: o_data = {16'h0, w_half};
`ifdef LOAD_SIGNED_EN
      OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      OP_LH:  o_data = {{16{w_half[15]}}, w_half};
`endif
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// MIPS load unit: accept in IDLE, one memory read with timeout, one-cycle writeback or error pulse.
// Min latency accept->wb_valid is 2 cycles; in_ready only in IDLE; LOAD_SIGNED_EN enables LB/LH.
module load_unit
  import mips_load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [4:0]  dest,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        load_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_in_ready;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_wb_valid;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic        r_load_err;
  logic [5:0]  r_op;
  logic [1:0]  r_lane;
  logic [4:0]  r_dest;
  logic [CW-1:0] r_cnt;

  logic        w_legal;
  logic [31:0] w_ext;

  assign w_legal = op_supported(opcode) && !addr_misaligned(opcode, addr[1:0]);

  load_align_ext u_align (
    .i_op    (r_op),
    .i_lane  (r_lane),
    .i_rdata (mem_rdata),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b1;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_wb_valid <= 1'b0;
      r_wb_reg   <= 5'h0;
      r_wb_data  <= 32'h0;
      r_load_err <= 1'b0;
      r_op       <= 6'h0;
      r_lane     <= 2'b00;
      r_dest     <= 5'h0;
      r_cnt      <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_op       <= opcode;
            r_lane     <= addr[1:0];
            r_dest     <= dest;
            if (w_legal) begin
              r_state    <= REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {addr[31:2], 2'b00};
              r_cnt      <= '0;
            end else begin
              r_state    <= ERR;
              r_load_err <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (mem_ack) begin
            r_state    <= WB;
            r_mem_req  <= 1'b0;
            r_wb_data  <= w_ext;
            r_wb_reg   <= r_dest;
            r_wb_valid <= (r_dest != 5'h0);
          end else if (r_cnt == LAST_WAIT) begin
            r_state    <= ERR;
            r_mem_req  <= 1'b0;
            r_load_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WB, ERR: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign wb_valid = r_wb_valid;
  assign wb_reg   = r_wb_reg;
  assign wb_data  = r_wb_data;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: scenario tasks with a queue of expected writeback results.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [4:0]  dest = 5'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_err;
    logic [4:0]  rg;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .addr      (addr),
    .dest      (dest),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [4:0] d, input logic [31:0] rd);
    exp_t e;
    logic [31:0] b;
    logic [31:0] h;
    e = '{is_err: 1'b0, rg: d, data: 32'h0};
    b = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
    h = (rd >> (16 * a[1])) & 32'h0000_FFFF;
    case (op)
      6'h23: if (a[1:0] != 2'b00) e.is_err = 1'b1; else e.data = rd;
      6'h24: e.data = b;
      6'h25: if (a[0]) e.is_err = 1'b1; else e.data = h;
`ifdef LOAD_SIGNED_EN
      6'h20: e.data = b[7] ? (b | 32'hFFFF_FF00) : b;
      6'h21: if (a[0]) e.is_err = 1'b1; else e.data = h[15] ? (h | 32'hFFFF_0000) : h;
`endif
      default: e.is_err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request; returns #1 after the accepting edge (cycle N+1).
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [4:0] d);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    opcode   = op;
    addr     = a;
    dest     = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: mem_req=%b wb_valid=%b load_err=%b required 0 0 0",
               mem_req, wb_valid, load_err);
    end
    checks++;
    if (mem_addr !== 32'h0 || wb_data !== 32'h0 || wb_reg !== 5'h0) begin
      errors++;
      $display("FAIL reset_data: mem_addr=%h wb_data=%h wb_reg=%0d required 0 0 0",
               mem_addr, wb_data, wb_reg);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_lbu();
    exp_t e;
    sb.push_back(model(6'h24, 32'h0000_1002, 5'd14, 32'h11AA_2233));
    send(6'h24, 32'h0000_1002, 5'd14);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL lbu_req: mem_req=%b mem_addr=%h in_ready=%b required 1 00001000 0",
               mem_req, mem_addr, in_ready);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h11AA_2233;
    tick();
    mem_ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || wb_reg !== e.rg || wb_data !== e.data || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lbu_wb: wb_valid=%b wb_reg=%0d wb_data=%h mem_req=%b required 1 %0d %h 0",
               wb_valid, wb_reg, wb_data, mem_req, e.rg, e.data);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lbu_after: wb_valid=%b in_ready=%b required 0 1", wb_valid, in_ready);
    end
  endtask

  task automatic test_lhu_wait();
    exp_t e;
    int pulses = 0;
    sb.push_back(model(6'h25, 32'h0000_2002, 5'd7, 32'h8001_FFFF));
    send(6'h25, 32'h0000_2002, 5'd7);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL lhu_hold: wait=%0d mem_req=%b mem_addr=%h wb_valid=%b required 1 00002000 0",
                 i, mem_req, mem_addr, wb_valid);
      end
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h8001_FFFF;
    tick();
    mem_ack = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      if (wb_valid === 1'b1) begin
        pulses++;
        checks++;
        if (wb_data !== e.data || wb_reg !== e.rg) begin
          errors++;
          $display("FAIL lhu_data: wb_reg=%0d wb_data=%h required %0d %h",
                   wb_reg, wb_data, e.rg, e.data);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL lhu_pulses: wb_valid pulses=%0d required 1", pulses);
    end
  endtask

  task automatic test_errors();
    logic [5:0]  ops[4]   = '{6'h23, 6'h25, 6'h22, 6'h0F};
    logic [31:0] addrs[4] = '{32'h0000_3001, 32'h0000_2001, 32'h0000_3000, 32'h0000_3004};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(ops[i], addrs[i], 5'd4, 32'h0));
      send(ops[i], addrs[i], 5'd4);
      e = sb.pop_front();
      checks++;
      if (load_err !== e.is_err || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse: case=%0d load_err=%b mem_req=%b wb_valid=%b required %b 0 0",
                 i, load_err, mem_req, wb_valid, e.is_err);
      end
      tick();
      checks++;
      if (load_err !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL err_after: case=%0d load_err=%b in_ready=%b mem_req=%b required 0 1 0",
                 i, load_err, in_ready, mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int req_cycles = 0;
    send(6'h23, 32'h0000_4000, 5'd3);
    while (mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles != 16) begin
      errors++;
      $display("FAIL timeout_len: mem_req cycles=%0d required 16", req_cycles);
    end
    checks++;
    if (load_err !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: load_err=%b wb_valid=%b required 1 0", load_err, wb_valid);
    end
    tick();
    checks++;
    if (load_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after: load_err=%b in_ready=%b required 0 1", load_err, in_ready);
    end
    // Ack in the last permitted wait cycle must complete the load.
    sb.push_back(model(6'h23, 32'h0000_4000, 5'd9, 32'hCAFE_F00D));
    send(6'h23, 32'h0000_4000, 5'd9);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_req: mem_req=%b required 1", mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (wb_valid !== 1'b1 || load_err !== 1'b0 || wb_data !== e.data || wb_reg !== e.rg) begin
      errors++;
      $display("FAIL timeout_edge_wb: wb_valid=%b load_err=%b wb_reg=%0d wb_data=%h required 1 0 %0d %h",
               wb_valid, load_err, wb_reg, wb_data, e.rg, e.data);
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_late: load_err=%b required 0", load_err);
    end
  endtask

  task automatic test_signed();
    logic [5:0]  ops[3]   = '{6'h20, 6'h21, 6'h21};
    logic [31:0] addrs[3] = '{32'h0000_5003, 32'h0000_5002, 32'h0000_5001};
    logic [31:0] rds[3]   = '{32'h8000_0000, 32'h8001_0000, 32'h0000_0000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(ops[i], addrs[i], 5'd11, rds[i]);
      sb.push_back(e);
      send(ops[i], addrs[i], 5'd11);
      if (mem_req === 1'b1) begin
        mem_ack = 1'b1;
        mem_rdata = rds[i];
        tick();
        mem_ack = 1'b0;
      end
      e = sb.pop_front();
      checks++;
      if (wb_valid !== !e.is_err || load_err !== e.is_err ||
          (!e.is_err && (wb_data !== e.data || wb_reg !== e.rg))) begin
        errors++;
        $display("FAIL signed: case=%0d wb_valid=%b load_err=%b wb_data=%h required %b %b %h",
                 i, wb_valid, load_err, wb_data, !e.is_err, e.is_err, e.data);
      end
      tick();
    end
  endtask

  task automatic test_dest0();
    send(6'h23, 32'h0000_6000, 5'd0);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_6000) begin
      errors++;
      $display("FAIL dest0_req: mem_req=%b mem_addr=%h required 1 00006000", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || load_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL dest0_wb: wb_valid=%b load_err=%b mem_req=%b required 0 0 0",
               wb_valid, load_err, mem_req);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL dest0_after: in_ready=%b wb_valid=%b required 1 0", in_ready, wb_valid);
    end
  endtask

  task automatic test_ack_outside();
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0 || mem_req !== 1'b0 || load_err !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL ack_idle: wb_valid=%b mem_req=%b load_err=%b in_ready=%b required 0 0 0 1",
                 wb_valid, mem_req, load_err, in_ready);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    int seen = 0;
    send(6'h23, 32'h0000_7000, 5'd5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_req: mem_req=%b required 0", mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready: in_ready=%b mem_req=%b required 1 0", in_ready, mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      if (wb_valid === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_wb: wb_valid pulses=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] rd;
    logic [4:0]  d;
    int          kind;
    int          dly;
    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom & 32'hFFFF_FFFC;
      rd   = $urandom;
      d    = 5'($urandom_range(1, 31));
      dly  = $urandom_range(0, 3);
      case (kind)
        0: op = 6'h23;
        1: begin op = 6'h24; a[1:0] = 2'($urandom_range(0, 3)); end
        default: begin op = 6'h25; a[1] = 1'($urandom_range(0, 1)); end
      endcase
      sb.push_back(model(op, a, d, rd));
      send(op, a, d);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00}) begin
        errors++;
        $display("FAIL b2b_req: n=%0d mem_req=%b mem_addr=%h required 1 %h",
                 n, mem_req, mem_addr, {a[31:2], 2'b00});
      end
      for (int i = 0; i < dly; i++) tick();
      mem_ack = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack = 1'b0;
      mem_rdata = ~rd;
      e = sb.pop_front();
      checks++;
      if (wb_valid !== 1'b1 || wb_reg !== e.rg || wb_data !== e.data) begin
        errors++;
        $display("FAIL b2b_wb: n=%0d op=%h addr=%h wb_valid=%b wb_reg=%0d wb_data=%h required 1 %0d %h",
                 n, op, a, wb_valid, wb_reg, wb_data, e.rg, e.data);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lbu();
    test_lhu_wait();
    test_errors();
    test_timeout();
    test_signed();
    test_dest0();
    test_ack_outside();
    test_reset_mid_req();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
